uart_rx_deserializer: RTL and testbench



---
 rtl/uart_rx_deserializer.sv | 154 +++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled start detection, 3-sample majority vote per bit,
// LSB-first data, optional parity and stop check, with one-cycle valid/error pulses.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                  state_q;
  logic [PRESCALE_W-1:0]   edge_cnt_q;
  logic [BW-1:0]           bit_cnt_q;
  logic [PRESCALE_W-1:0]   prescale_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic [2:0]              samp_q;
  logic                    bit_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic                    par_bad_q;
  logic [DATA_WIDTH-1:0]   p_data_q;
  logic                    data_valid_q;
  logic                    par_err_q;
  logic                    stp_err_q;
  logic                    busy_q;

  logic [PRESCALE_W-1:0]   half_d;
  logic                    at_last_d;
  logic                    samp_en_d;
  logic                    vote_en_d;
  logic                    vote_d;

  // Sample window is centred on the middle of the bit; the vote is registered two
  // cycles later so it is stable well before the bit-boundary decision.
  always_comb begin
    half_d    = prescale_q >> 1;
    at_last_d = (edge_cnt_q == prescale_q - ONE);
    samp_en_d = (edge_cnt_q == half_d - ONE) || (edge_cnt_q == half_d) ||
                (edge_cnt_q == half_d + ONE);
    vote_en_d = (edge_cnt_q == half_d + TWO);
    vote_d    = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      prescale_q   <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      samp_q       <= '0;
      bit_q        <= 1'b0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      if (state_q != IDLE) begin
        edge_cnt_q <= at_last_d ? '0 : edge_cnt_q + ONE;
        if (samp_en_d) samp_q <= {samp_q[1:0], rx_in};
        if (vote_en_d) bit_q <= vote_d;
      end
      case (state_q)
        IDLE: begin
          // The detecting cycle is edge 0 of the start bit, so counting resumes at 1.
          if (!rx_in) begin
            state_q    <= START;
            busy_q     <= 1'b1;
            edge_cnt_q <= ONE;
            prescale_q <= prescale;
            par_en_q   <= par_en;
            par_typ_q  <= par_typ;
            bit_cnt_q  <= '0;
            par_bad_q  <= 1'b0;
          end
        end
        START: begin
          if (at_last_d) begin
            if (bit_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (at_last_d) begin
            shift_q[bit_cnt_q] <= bit_q;
            if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (at_last_d) begin
            par_bad_q <= bit_q ^ (^shift_q) ^ par_typ_q;
            state_q   <= STOP;
          end
        end
        STOP: begin
          if (at_last_d) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            par_err_q <= par_bad_q;
            stp_err_q <= ~bit_q;
            if (!par_bad_q && bit_q) begin
              data_valid_q <= 1'b1;
              p_data_q     <= shift_q;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign p_data     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign busy       = busy_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed scenarios plus randomized frames checked
// against a frame-level model of expected result and completion cycle.
module tb_uart_rx_deserializer;
  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          par_en;
  logic          par_typ;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
  logic          busy;
  logic [2:0]    state_dbg;

  uart_rx_deserializer #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .prescale(prescale),
    .par_en(par_en), .par_typ(par_typ), .p_data(p_data),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entry = {stp_err, par_err, data_valid, p_data} expected when the frame completes.
  logic [DW+2:0] exp_q[$];
  int            exp_cyc_q[$];
  int            dv_cyc_q[$];
  logic [DW-1:0] last_good;
  logic [DW+2:0] mon_e;
  int            mon_ec;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (data_valid || par_err || stp_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, stp_err, par_err, data_valid}, 32'd0);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ec = exp_cyc_q.pop_front();
        check("frame_result", {stp_err, par_err, data_valid, p_data}, mon_e);
        check("frame_cycle", cyc, mon_ec);
      end
      if (data_valid) dv_cyc_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [PW-1:0] pick_p();
    case ($urandom_range(0, 2))
      0:       return PW'(8);
      1:       return PW'(16);
      default: return PW'(32);
    endcase
  endfunction

  task automatic drive_line(input logic [15:0] bits, input int nbits, input int p,
                            input int flip_idx, input bit perturb);
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < p; k++) begin
        rx_in = (b == flip_idx && k == p / 2) ? ~bits[b] : bits[b];
        if (perturb && b == 1 && k == 0) begin
          prescale = pick_p();
          par_en   = 1'($urandom_range(0, 1));
          par_typ  = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
      end
    end
  endtask

  // Model: a frame is start, DW data bits LSB first, optional parity, stop. It completes
  // (1+DW+par_en+1)*p cycles after its first start cycle; data is good only when the
  // parity bit gives the requested parity and the stop bit is high.
  task automatic send_frame(input logic [DW-1:0] d, input int p, input bit pe, input bit pt,
                            input bit bad_par, input bit stop_val, input int flip_idx,
                            input bit perturb);
    logic [15:0] bits;
    int          n;
    int          ones;
    bit          good_par;
    bit          perr;
    bit          serr;
    ones     = $countones(d);
    good_par = pt ? (ones % 2 == 0) : (ones % 2 == 1);
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < DW; i++) begin
      bits[n] = d[i]; n++;
    end
    if (pe) begin
      bits[n] = bad_par ? ~good_par : good_par; n++;
    end
    bits[n] = stop_val; n++;
    perr = pe && bad_par;
    serr = !stop_val;
    prescale = PW'(p);
    par_en   = pe;
    par_typ  = pt;
    if (!perr && !serr) last_good = d;
    exp_q.push_back({serr, perr, (!perr && !serr), last_good});
    exp_cyc_q.push_back(cyc + n * p);
    drive_line(bits, n, p, flip_idx, perturb);
    rx_in = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    check("drain_timeout", exp_q.size(), 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  int c0;
  int fl;
  int c_end;

  initial begin
    rst_n     = 1'b0;
    rx_in     = 1'b1;
    prescale  = PW'(8);
    par_en    = 1'b0;
    par_typ   = 1'b0;
    last_good = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_p_data", p_data, 32'd0);
    check("rst_data_valid", data_valid, 32'd0);
    check("rst_par_err", par_err, 32'd0);
    check("rst_stp_err", stp_err, 32'd0);
    check("rst_busy", busy, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);

    // Clean frame with even parity; latency counted with the start cycle as cycle 1.
    dv_cyc_q.delete();
    c0 = cyc;
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    drain();
    check("dv_count_a5", dv_cyc_q.size(), 32'd1);
    if (dv_cyc_q.size() > 0) check("dv_latency", dv_cyc_q[0] - c0 + 1, (1 + DW + 1 + 1) * 8 + 1);
    check("p_data_a5", p_data, 32'hA5);
    idle(5);

    // Odd parity with wrong parity bit, then stop error at prescale 32.
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0);
    drain();
    idle(3);
    send_frame(8'h5A, 32, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    drain();
    @(negedge clk);
    check("idle_after_stp", busy, 32'd0);
    check("held_p_data", p_data, 32'hA5);
    @(posedge clk); #1;
    idle(5);

    // Two-cycle low glitch: false start, busy for cycles 1..7 only.
    prescale = PW'(8);
    rx_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("glitch_busy", busy, {31'd0, (k >= 1 && k <= 7)});
      @(posedge clk); #1;
      if (k == 1) rx_in = 1'b1;
    end
    idle(4);

    // Back-to-back frames, the second with a single flipped mid-bit sample.
    dv_cyc_q.delete();
    send_frame(8'h01, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    send_frame(8'hFE, 16, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0);
    drain();
    check("b2b_dv_count", dv_cyc_q.size(), 32'd2);
    if (dv_cyc_q.size() == 2) check("b2b_spacing", dv_cyc_q[1] - dv_cyc_q[0], (2 + DW) * 16);
    idle(5);

    // Reset during data bit 4 aborts silently; the next frame is received cleanly.
    prescale = PW'(8);
    par_en   = 1'b0;
    drive_line(16'b0000_0000_0000_0010, 5, 8, -1, 1'b0);
    rx_in = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 32'd0);
    check("abort_p_data", p_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_good = '0;
    idle(3);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    drain();
    check("p_data_81", p_data, 32'h81);
    idle(5);

    // Line stuck low after a stop error: further all-zero frames, each with stp_err.
    fl = (2 + DW) * 8;
    send_frame(8'h33, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    rx_in = 1'b0;
    c_end = cyc;
    exp_q.push_back({1'b1, 1'b0, 1'b0, last_good});
    exp_cyc_q.push_back(c_end + fl);
    exp_q.push_back({1'b1, 1'b0, 1'b0, last_good});
    exp_cyc_q.push_back(c_end + 2 * fl);
    repeat (2 * fl) begin
      @(posedge clk); #1;
    end
    rx_in = 1'b1;
    drain();
    idle(5);

    // Randomized frames with config changes mid-frame and random gaps.
    for (int f = 0; f < 40; f++) begin
      logic [PW-1:0] rp;
      bit            rpe;
      rp  = pick_p();
      rpe = 1'($urandom_range(0, 1));
      send_frame(8'($urandom_range(0, 255)), int'(rp), rpe, 1'($urandom_range(0, 1)),
                 rpe && ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DW)) : -1,
                 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 20));
    end
    drain();
    check("final_p_data", p_data, last_good);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
